// File: rtl/data_memory_stage.sv
// data_memory_stage
//   MEM-stage data memory of the 5-stage pipeline. The ALU result is used as a
//   little-endian byte address for byte, halfword and word loads and stores.
//   Load data is combinational so MEM/WB captures it on the same clock edge.
//   Stores commit at the rising edge that ends the access cycle.
//
//   There is no valid/ready handshake. Every access completes in its own
//   cycle, and MemRead/MemWrite act as per-cycle enables.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; clears the array and fault
//   address       byte address (ALU result from EX/MEM)
//   writedata     store data; low bytes used for byte/half stores
//   MemRead       load enable
//   MemWrite      store enable
//   memsize       00 byte, 01 half, 10 word, 11 illegal
//   memunsigned   1 zero-extend loads, 0 sign-extend loads
//   memreadresult combinational load data (0 when not reading or misaligned)
//   misaligned    combinational: current access is misaligned or illegal
//   fault         registered sticky error flag, cleared only by reset
module data_memory_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  memsize,
  input  logic        memunsigned,
  output logic [31:0] memreadresult,
  output logic        misaligned,
  output logic        fault
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0]          mem [DEPTH_WORDS];
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic [31:0]          rd_word;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic                 store_en;

  // Upper address bits are ignored, so addresses wrap modulo the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_BITS+2];

  assign word_idx = address[ADDR_BITS+1:2];
  assign lane     = address[1:0];
  assign rd_word  = mem[word_idx];

  // Alignment is judged on every cycle, whether or not an access is enabled.
  always_comb begin
    misaligned = 1'b0;
    case (memsize)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Load path. During a same-cycle read and write this shows the pre-write
  // contents, because the store only lands at the closing edge.
  always_comb begin
    rd_byte = 8'h00;
    case (lane)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    memreadresult = 32'h0000_0000;
    if (MemRead && !misaligned) begin
      case (memsize)
        SZ_BYTE: memreadresult = {{24{~memunsigned & rd_byte[7]}}, rd_byte};
        SZ_HALF: memreadresult = {{16{~memunsigned & rd_half[15]}}, rd_half};
        default: memreadresult = rd_word;
      endcase
    end
  end

  assign store_en = MemWrite && !misaligned;

  // Reset takes priority over a store in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'h0000_0000;
      end
      fault <= 1'b0;
    end else begin
      if (store_en) begin
        case (memsize)
          SZ_BYTE: begin
            case (lane)
              2'd0: mem[word_idx][7:0]   <= writedata[7:0];
              2'd1: mem[word_idx][15:8]  <= writedata[7:0];
              2'd2: mem[word_idx][23:16] <= writedata[7:0];
              default: mem[word_idx][31:24] <= writedata[7:0];
            endcase
          end
          SZ_HALF: begin
            if (lane[1]) mem[word_idx][31:16] <= writedata[15:0];
            else         mem[word_idx][15:0]  <= writedata[15:0];
          end
          default: mem[word_idx] <= writedata;
        endcase
      end
      if ((MemRead || MemWrite) && misaligned) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: reset state, byte/half/word loads
// and stores, misalignment and sticky fault, same-cycle read/write, address
// wrap and reset-over-store priority.
module tb_data_memory_stage;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  memsize;
  logic        memunsigned;
  logic [31:0] memreadresult;
  logic        misaligned;
  logic        fault;

  int vectors;
  int miscompares;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] X = 2'b11;

  data_memory_stage #(.DEPTH_WORDS(256), .ADDR_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .writedata(writedata),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .memsize(memsize),
    .memunsigned(memunsigned),
    .memreadresult(memreadresult),
    .misaligned(misaligned),
    .fault(fault)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns);
    address     = a;
    writedata   = wd;
    MemRead     = rd;
    MemWrite    = wr;
    memsize     = sz;
    memunsigned = uns;
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0, 1'b0, W, 1'b0);
  endtask

  // advance past the next rising edge; inputs change 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    drive(a, 32'h0, 1'b1, 1'b0, sz, uns);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    drive(a, wd, 1'b0, 1'b1, sz, 1'b0);
    step();
    idle();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle();

    // reset
    step();
    step();
    reset = 1'b0;
    check("reset_fault", {31'b0, fault}, 32'h0);
    load(32'h000, W, 1'b0); check("reset_w00", memreadresult, 32'h0000_0000);
    load(32'h004, W, 1'b0); check("reset_w04", memreadresult, 32'h0000_0000);
    load(32'h3FC, W, 1'b0); check("reset_w3fc", memreadresult, 32'h0000_0000);

    // word store then sub-word loads
    store(32'h010, 32'h80FF_7F01, W);
    load(32'h010, W, 1'b0); check("w10", memreadresult, 32'h80FF_7F01);
    drive(32'h010, 32'h0, 1'b0, 1'b0, W, 1'b0);
    check("noread_zero", memreadresult, 32'h0000_0000);
    load(32'h010, B, 1'b0); check("lb10", memreadresult, 32'h0000_0001);
    load(32'h011, B, 1'b0); check("lb11", memreadresult, 32'h0000_007F);
    load(32'h012, B, 1'b0); check("lb12", memreadresult, 32'hFFFF_FFFF);
    load(32'h013, B, 1'b0); check("lb13", memreadresult, 32'hFFFF_FF80);
    load(32'h013, B, 1'b1); check("lbu13", memreadresult, 32'h0000_0080);
    load(32'h012, H, 1'b0); check("lh12", memreadresult, 32'hFFFF_80FF);
    load(32'h012, H, 1'b1); check("lhu12", memreadresult, 32'h0000_80FF);
    load(32'h010, H, 1'b0); check("lh10", memreadresult, 32'h0000_7F01);
    load(32'h010, W, 1'b1); check("w10_uns_ignored", memreadresult, 32'h80FF_7F01);

    // partial stores leave other lanes untouched
    store(32'h011, 32'hFFFF_FFAB, B);
    load(32'h010, W, 1'b0); check("sb11", memreadresult, 32'h80FF_AB01);
    store(32'h012, 32'hABCD_1234, H);
    load(32'h010, W, 1'b0); check("sh12", memreadresult, 32'h1234_AB01);
    check("fault_clean", {31'b0, fault}, 32'h0);

    // misaligned and illegal accesses
    store(32'h020, 32'hCAFE_F00D, W);
    drive(32'h021, 32'hDEAD_BEEF, 1'b0, 1'b1, W, 1'b0);
    check("mis_w21", {31'b0, misaligned}, 32'h1);
    check("fault_not_yet", {31'b0, fault}, 32'h0);
    step();
    idle();
    check("fault_set", {31'b0, fault}, 32'h1);
    load(32'h020, W, 1'b0); check("w20_unchanged", memreadresult, 32'hCAFE_F00D);
    load(32'h023, H, 1'b0);
    check("mis_h23", {31'b0, misaligned}, 32'h1);
    check("lh23_zero", memreadresult, 32'h0000_0000);
    load(32'h022, H, 1'b1);
    check("mis_h22", {31'b0, misaligned}, 32'h0);
    check("lhu22", memreadresult, 32'h0000_CAFE);
    load(32'h020, X, 1'b0);
    check("mis_illegal", {31'b0, misaligned}, 32'h1);
    check("illegal_zero", memreadresult, 32'h0000_0000);
    drive(32'h023, 32'h0, 1'b0, 1'b0, B, 1'b0);
    check("mis_b23", {31'b0, misaligned}, 32'h0);
    idle();
    step();
    step();
    check("fault_sticky", {31'b0, fault}, 32'h1);

    // same-cycle read and write
    store(32'h030, 32'h1111_1111, W);
    drive(32'h030, 32'h2222_2222, 1'b1, 1'b1, W, 1'b0);
    check("rw_old", memreadresult, 32'h1111_1111);
    step();
    load(32'h030, W, 1'b0); check("rw_new", memreadresult, 32'h2222_2222);

    // address wrap
    store(32'h430, 32'h3333_3333, W);
    load(32'h030, W, 1'b0); check("wrap_030", memreadresult, 32'h3333_3333);

    // reset beats a store
    reset = 1'b1;
    drive(32'h040, 32'h5555_5555, 1'b0, 1'b1, W, 1'b0);
    step();
    reset = 1'b0;
    idle();
    check("rst_fault", {31'b0, fault}, 32'h0);
    load(32'h040, W, 1'b0); check("rst_w40", memreadresult, 32'h0000_0000);
    load(32'h030, W, 1'b0); check("rst_w30", memreadresult, 32'h0000_0000);
    load(32'h010, W, 1'b0); check("rst_w10", memreadresult, 32'h0000_0000);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
